// File: rtl/rob_pkg.sv
// Shared widths, reserved encodings and the slot record for the in-order commit stage.
package rob_pkg;

    localparam int NALU   = 3;
    localparam int CNT_W  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int REG_W  = 5;
    localparam int UNIT_W = 3;
    localparam int NSLOT  = NALU + 1;

    localparam logic [CNT_W-1:0]  CntFirst = '0;
    localparam logic [CNT_W-1:0]  CntLast  = '1;
    localparam logic [UNIT_W-1:0] NoUnit   = '0;
    localparam logic [UNIT_W-1:0] MemUnit  = UNIT_W'(NALU + 1);

    // One finished result waiting to retire.
    typedef struct packed {
        logic              valid;
        logic [CNT_W-1:0]  cnt;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
        logic              jmp;
        logic [ADDR_W-1:0] jaddr;
    } slot_t;

    // Issue counter successor; CntFirst means "no instruction" and is skipped.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c);
        return (c == CntLast) ? CNT_W'(1) : c + CNT_W'(1);
    endfunction

endpackage

// File: rtl/rob_slot.sv
// One per-unit result slot: capture, clear on commit, tag compare, overwrite detect.
module rob_slot
    import rob_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             cap_vld,
    input  slot_t            cap,
    input  logic             clr,
    input  logic [CNT_W-1:0] expected,
    output slot_t            ent,
    output logic             match,
    output logic             err
);

    logic cap_ok;

    // A unit may refill its slot on the same edge the old entry retires.
    assign cap_ok = cap_vld && (cap.cnt != CntFirst) && (!ent.valid || clr);
    assign err    = cap_vld && ((cap.cnt == CntFirst) || (ent.valid && !clr));
    assign match  = ent.valid && (ent.cnt == expected);

    // Capture wins over clear so a same-edge refill survives the commit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ent <= '0;
        end else if (cap_ok) begin
            ent       <= cap;
            ent.valid <= 1'b1;
        end else if (clr) begin
            ent.valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rob_commit.sv
// In-order commit: per-unit result slots, retire the slot holding the expected tag.
module rob_commit
    import rob_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NALU-1:0]          i_ALU_valid,
    input  logic [NALU*CNT_W-1:0]    i_ALU_cnt,
    input  logic [NALU*REG_W-1:0]    i_ALU_rd,
    input  logic [NALU*DATA_W-1:0]   i_ALU_data,
    input  logic [NALU-1:0]          i_ALU_jmp,
    input  logic [NALU*ADDR_W-1:0]   i_ALU_jaddr,
    input  logic                     i_MEM_valid,
    input  logic [CNT_W-1:0]         i_MEM_cnt,
    input  logic [REG_W-1:0]         i_MEM_rd,
    input  logic [DATA_W-1:0]        i_MEM_data,
    output logic [REG_W-1:0]         o_IDSUE_wreg,
    output logic [DATA_W-1:0]        o_IDSUE_wdata,
    output logic [UNIT_W-1:0]        o_IDSUE_free,
    output logic                     o_PCREG_jmp,
    output logic [ADDR_W-1:0]        o_PCREG_addr,
    output logic                     o_err
);

    slot_t              cap [NSLOT];
    slot_t              ent [NSLOT];
    logic [NSLOT-1:0]   cap_vld;
    logic [NSLOT-1:0]   match;
    logic [NSLOT-1:0]   slot_err;
    logic [CNT_W-1:0]   expected;
    slot_t              sel;
    logic [UNIT_W-1:0]  sel_unit;

    assign cap_vld = {i_MEM_valid, i_ALU_valid};

    genvar u;
    generate
        for (u = 0; u < NALU; u++) begin : g_alu_cap
            assign cap[u] = '{valid: 1'b1,
                              cnt:   i_ALU_cnt[u*CNT_W +: CNT_W],
                              rd:    i_ALU_rd[u*REG_W +: REG_W],
                              data:  i_ALU_data[u*DATA_W +: DATA_W],
                              jmp:   i_ALU_jmp[u],
                              jaddr: i_ALU_jaddr[u*ADDR_W +: ADDR_W]};
        end
    endgenerate

    // MEM never redirects.
    assign cap[NALU] = '{valid: 1'b1, cnt: i_MEM_cnt, rd: i_MEM_rd,
                         data: i_MEM_data, jmp: 1'b0, jaddr: '0};

    generate
        for (u = 0; u < NSLOT; u++) begin : g_slot
            rob_slot u_slot (
                .clk      (clk),
                .rst      (rst),
                .cap_vld  (cap_vld[u]),
                .cap      (cap[u]),
                .clr      (match[u]),
                .expected (expected),
                .ent      (ent[u]),
                .match    (match[u]),
                .err      (slot_err[u])
            );
        end
    endgenerate

    // Tags are unique among live slots, so match is one-hot and an OR mux suffices.
    always_comb begin
        sel      = '0;
        sel_unit = NoUnit;
        for (int k = 0; k < NSLOT; k++) begin
            if (match[k]) begin
                sel      = sel | ent[k];
                sel_unit = sel_unit | UNIT_W'(k + 1);
            end
        end
    end

    // Retire register bank and expected-tag counter; wdata/addr hold when idle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            expected      <= CNT_W'(1);
            o_IDSUE_wreg  <= '0;
            o_IDSUE_wdata <= '0;
            o_IDSUE_free  <= NoUnit;
            o_PCREG_jmp   <= 1'b0;
            o_PCREG_addr  <= '0;
            o_err         <= 1'b0;
        end else begin
            o_err <= o_err | (|slot_err);
            if (|match) begin
                expected      <= cnt_next(expected);
                o_IDSUE_free  <= sel_unit;
                o_IDSUE_wreg  <= sel.rd;   // rd=0 already encodes "no write"
                o_IDSUE_wdata <= sel.data;
                o_PCREG_jmp   <= sel.jmp;
                o_PCREG_addr  <= sel.jaddr;
            end else begin
                o_IDSUE_free  <= NoUnit;
                o_IDSUE_wreg  <= '0;
                o_PCREG_jmp   <= 1'b0;
            end
        end
    end

endmodule
